lsu_ctrl: RTL and testbench

Load/store sequencer between the execute stage (decoded memory op plus ALU address) and the single-ported data memory bus.
- Accepts one load/store at a time, aligns byte lanes, and runs a req/ack handshake with a timeout.
- Sign- or zero-extends load data and presents the write-back.
- Holds the core via stall while a transaction is outstanding; flags misaligned and faulting accesses.

---
 rtl/lsu_pkg.sv | 41 ++++
 rtl/lsu_lane_align.sv | 40 ++++
 rtl/lsu_ctrl.sv | 225 ++++++++++++++++++++++
 tb/tb_lsu_ctrl.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store sequencer: FSM states, access sizes,
// funct3 values and the byte-enable mask helper.
package lsu_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUS  = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;
  localparam logic [1:0] ST_EXC  = 2'd3;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;
  localparam logic [2:0] F3_SD  = 3'b011;

  // 3'b111 has no load encoding in RV64I
  localparam logic [2:0] F3_LOAD_ILLEGAL = 3'b111;

  function automatic logic [7:0] be_mask(input logic [1:0] size, input logic [2:0] offset);
    logic [7:0] base;
    case (size)
      SZ_B:    base = 8'h01;
      SZ_H:    base = 8'h03;
      SZ_W:    base = 8'h0F;
      default: base = 8'hFF;
    endcase
    return base << offset;
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering: store data/byte-enable placement on the way out and
// load data shift plus sign/zero extension on the way back.
module lsu_lane_align
  import lsu_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [1:0]      st_size,
  input  logic [2:0]      st_offset,
  input  logic [XLEN-1:0] st_wdata,
  output logic [7:0]      st_be,
  output logic [XLEN-1:0] st_wdata_sh,
  input  logic [1:0]      ld_size,
  input  logic            ld_unsigned,
  input  logic [2:0]      ld_offset,
  input  logic [XLEN-1:0] ld_rdata,
  output logic [XLEN-1:0] ld_data
);

  logic [XLEN-1:0] ld_sh;

  always_comb begin
    st_be       = be_mask(st_size, st_offset);
    st_wdata_sh = st_wdata << {st_offset, 3'b000};
  end

  always_comb begin
    ld_sh = ld_rdata >> {ld_offset, 3'b000};
    case (ld_size)
      SZ_B:    ld_data = ld_unsigned ? {56'd0, ld_sh[7:0]}
                                     : {{56{ld_sh[7]}}, ld_sh[7:0]};
      SZ_H:    ld_data = ld_unsigned ? {48'd0, ld_sh[15:0]}
                                     : {{48{ld_sh[15]}}, ld_sh[15:0]};
      SZ_W:    ld_data = ld_unsigned ? {32'd0, ld_sh[31:0]}
                                     : {{32{ld_sh[31]}}, ld_sh[31:0]};
      default: ld_data = ld_sh;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store sequencer: accepts one memory op, drives a registered req/ack
// bus transaction with timeout, and returns extended load data or a fault.
//
// state | meaning
// IDLE  | waiting for a load/store from execute
// BUS   | mem_req asserted, waiting for mem_ack or timeout
// RESP  | wb_valid pulse for a completed load
// EXC   | misaligned or access_fault pulse
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int XLEN           = 64,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  input  logic            is_load,
  input  logic            is_store,
  input  logic [2:0]      func3,
  input  logic [XLEN-1:0] addr,
  input  logic [XLEN-1:0] wdata,
  input  logic [4:0]      rd,
  output logic            stall,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [7:0]      mem_be,
  output logic [XLEN-1:0] mem_wdata,
  input  logic            mem_ack,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            wb_valid,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_data,
  output logic            misaligned,
  output logic            access_fault,
  output logic [XLEN-1:0] fault_addr
);

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] TO_LIMIT = CW'(TIMEOUT_CYCLES);
  localparam bit TO_EN = (TIMEOUT_CYCLES != 0);

  logic [1:0]      state_q, state_d;
  logic            mem_req_q, mem_req_d;
  logic            mem_we_q, mem_we_d;
  logic [XLEN-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]      mem_be_q, mem_be_d;
  logic [XLEN-1:0] mem_wdata_q, mem_wdata_d;
  logic            wb_valid_q, wb_valid_d;
  logic [4:0]      wb_rd_q, wb_rd_d;
  logic [XLEN-1:0] wb_data_q, wb_data_d;
  logic            misaligned_q, misaligned_d;
  logic            access_fault_q, access_fault_d;
  logic [XLEN-1:0] fault_addr_q, fault_addr_d;
  logic [XLEN-1:0] op_addr_q, op_addr_d;
  logic [2:0]      func3_q, func3_d;
  logic [2:0]      offset_q, offset_d;
  logic            op_load_q, op_load_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic            accept;
  logic            op_store;
  logic            illegal;
  logic            misal;
  logic [2:0]      offset;
  logic [1:0]      size;
  logic [CW-1:0]   cnt_nxt;
  logic [7:0]      st_be;
  logic [XLEN-1:0] st_wdata_sh;
  logic [XLEN-1:0] ld_data;

  assign offset   = addr[2:0];
  assign size     = func3[1:0];
  assign op_store = is_store;
  assign accept   = (state_q == ST_IDLE) && req_valid && (is_load || is_store);
  assign cnt_nxt  = cnt_q + CW'(1);

  always_comb begin
    illegal = op_store ? func3[2] : (func3 == F3_LOAD_ILLEGAL);
    case (size)
      SZ_B:    misal = 1'b0;
      SZ_H:    misal = offset[0];
      SZ_W:    misal = |offset[1:0];
      default: misal = |offset;
    endcase
  end

  lsu_lane_align #(.XLEN(XLEN)) u_align (
    .st_size     (size),
    .st_offset   (offset),
    .st_wdata    (wdata),
    .st_be       (st_be),
    .st_wdata_sh (st_wdata_sh),
    .ld_size     (func3_q[1:0]),
    .ld_unsigned (func3_q[2]),
    .ld_offset   (offset_q),
    .ld_rdata    (mem_rdata),
    .ld_data     (ld_data)
  );

  always_comb begin
    state_d        = state_q;
    mem_req_d      = mem_req_q;
    mem_we_d       = mem_we_q;
    mem_addr_d     = mem_addr_q;
    mem_be_d       = mem_be_q;
    mem_wdata_d    = mem_wdata_q;
    wb_valid_d     = 1'b0;
    wb_rd_d        = wb_rd_q;
    wb_data_d      = wb_data_q;
    misaligned_d   = 1'b0;
    access_fault_d = 1'b0;
    fault_addr_d   = fault_addr_q;
    op_addr_d      = op_addr_q;
    func3_d        = func3_q;
    offset_d       = offset_q;
    op_load_d      = op_load_q;
    cnt_d          = cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          // illegal encoding outranks misalignment
          if (illegal) begin
            state_d        = ST_EXC;
            access_fault_d = 1'b1;
            fault_addr_d   = addr;
          end else if (misal) begin
            state_d      = ST_EXC;
            misaligned_d = 1'b1;
            fault_addr_d = addr;
          end else begin
            state_d     = ST_BUS;
            mem_req_d   = 1'b1;
            mem_we_d    = op_store;
            mem_addr_d  = {addr[XLEN-1:3], 3'b000};
            mem_be_d    = st_be;
            mem_wdata_d = st_wdata_sh;
            wb_rd_d     = rd;
            func3_d     = func3;
            offset_d    = offset;
            op_addr_d   = addr;
            op_load_d   = !op_store;
            cnt_d       = '0;
          end
        end
      end
      ST_BUS: begin
        if (mem_ack) begin
          mem_req_d = 1'b0;
          if (op_load_q) begin
            state_d    = ST_RESP;
            wb_valid_d = 1'b1;
            wb_data_d  = ld_data;
          end else begin
            state_d = ST_IDLE;
          end
        end else if (TO_EN && (cnt_nxt == TO_LIMIT)) begin
          mem_req_d      = 1'b0;
          state_d        = ST_EXC;
          access_fault_d = 1'b1;
          fault_addr_d   = op_addr_q;
        end else begin
          cnt_d = cnt_nxt;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      mem_req_q      <= 1'b0;
      mem_we_q       <= 1'b0;
      mem_addr_q     <= '0;
      mem_be_q       <= '0;
      mem_wdata_q    <= '0;
      wb_valid_q     <= 1'b0;
      wb_rd_q        <= '0;
      wb_data_q      <= '0;
      misaligned_q   <= 1'b0;
      access_fault_q <= 1'b0;
      fault_addr_q   <= '0;
      op_addr_q      <= '0;
      func3_q        <= '0;
      offset_q       <= '0;
      op_load_q      <= 1'b0;
      cnt_q          <= '0;
    end else begin
      state_q        <= state_d;
      mem_req_q      <= mem_req_d;
      mem_we_q       <= mem_we_d;
      mem_addr_q     <= mem_addr_d;
      mem_be_q       <= mem_be_d;
      mem_wdata_q    <= mem_wdata_d;
      wb_valid_q     <= wb_valid_d;
      wb_rd_q        <= wb_rd_d;
      wb_data_q      <= wb_data_d;
      misaligned_q   <= misaligned_d;
      access_fault_q <= access_fault_d;
      fault_addr_q   <= fault_addr_d;
      op_addr_q      <= op_addr_d;
      func3_q        <= func3_d;
      offset_q       <= offset_d;
      op_load_q      <= op_load_d;
      cnt_q          <= cnt_d;
    end
  end

  assign stall        = accept || (state_q == ST_BUS);
  assign mem_req      = mem_req_q;
  assign mem_we       = mem_we_q;
  assign mem_addr     = mem_addr_q;
  assign mem_be       = mem_be_q;
  assign mem_wdata    = mem_wdata_q;
  assign wb_valid     = wb_valid_q;
  assign wb_rd        = wb_rd_q;
  assign wb_data      = wb_data_q;
  assign misaligned   = misaligned_q;
  assign access_fault = access_fault_q;
  assign fault_addr   = fault_addr_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl with a short timeout so the fault path is quick.
module tb_lsu_ctrl;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        is_load;
  logic        is_store;
  logic [2:0]  func3;
  logic [63:0] addr;
  logic [63:0] wdata;
  logic [4:0]  rd;
  logic        stall;
  logic        mem_req;
  logic        mem_we;
  logic [63:0] mem_addr;
  logic [7:0]  mem_be;
  logic [63:0] mem_wdata;
  logic        mem_ack;
  logic [63:0] mem_rdata;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [63:0] wb_data;
  logic        misaligned;
  logic        access_fault;
  logic [63:0] fault_addr;

  int n_assert = 0;
  int n_fail   = 0;

  lsu_ctrl #(.XLEN(64), .TIMEOUT_CYCLES(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .is_load      (is_load),
    .is_store     (is_store),
    .func3        (func3),
    .addr         (addr),
    .wdata        (wdata),
    .rd           (rd),
    .stall        (stall),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_be       (mem_be),
    .mem_wdata    (mem_wdata),
    .mem_ack      (mem_ack),
    .mem_rdata    (mem_rdata),
    .wb_valid     (wb_valid),
    .wb_rd        (wb_rd),
    .wb_data      (wb_data),
    .misaligned   (misaligned),
    .access_fault (access_fault),
    .fault_addr   (fault_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic ld, input logic st, input logic [2:0] f3,
                       input logic [63:0] a, input logic [63:0] wd, input logic [4:0] r);
    req_valid = 1'b1;
    is_load   = ld;
    is_store  = st;
    func3     = f3;
    addr      = a;
    wdata     = wd;
    rd        = r;
  endtask

  task automatic drop();
    req_valid = 1'b0;
    is_load   = 1'b0;
    is_store  = 1'b0;
  endtask

  initial begin
    int stall_cnt;
    int wb_seen;
    int req_cnt;
    int flt_cnt;

    rst_n = 1'b0;
    req_valid = 1'b0; is_load = 1'b0; is_store = 1'b0;
    func3 = 3'd0; addr = '0; wdata = '0; rd = '0;
    mem_ack = 1'b0; mem_rdata = '0;
    #12;
    chk("rst_mem_req", {63'd0, mem_req}, 64'd0);
    chk("rst_stall", {63'd0, stall}, 64'd0);
    chk("rst_mem_be", {56'd0, mem_be}, 64'd0);
    chk("rst_wb_valid", {63'd0, wb_valid}, 64'd0);
    chk("rst_fault_addr", fault_addr, 64'd0);
    chk("rst_faults", {62'd0, misaligned, access_fault}, 64'd0);
    step();
    rst_n = 1'b1;
    step();

    // op with neither flag set, plus a stray ack, must be ignored
    req_valid = 1'b1; func3 = 3'd2; addr = 64'h10; mem_ack = 1'b1;
    #1;
    chk("ign_stall", {63'd0, stall}, 64'd0);
    step();
    chk("ign_mem_req", {63'd0, mem_req}, 64'd0);
    chk("ign_wb_valid", {63'd0, wb_valid}, 64'd0);
    drop(); mem_ack = 1'b0;

    // LW 0x1004
    issue(1'b1, 1'b0, 3'b010, 64'h1004, 64'd0, 5'd5);
    #1;
    chk("lw_stall_acc", {63'd0, stall}, 64'd1);
    step();
    drop();
    chk("lw_mem_req", {63'd0, mem_req}, 64'd1);
    chk("lw_mem_we", {63'd0, mem_we}, 64'd0);
    chk("lw_mem_addr", mem_addr, 64'h1000);
    chk("lw_mem_be", {56'd0, mem_be}, 64'hF0);
    chk("lw_stall_bus", {63'd0, stall}, 64'd1);
    mem_ack = 1'b1; mem_rdata = 64'h8000_0001_1234_5678;
    step();
    mem_ack = 1'b0;
    chk("lw_wb_valid", {63'd0, wb_valid}, 64'd1);
    chk("lw_wb_data", wb_data, 64'hFFFF_FFFF_8000_0001);
    chk("lw_wb_rd", {59'd0, wb_rd}, 64'd5);
    chk("lw_req_drop", {63'd0, mem_req}, 64'd0);
    chk("lw_stall_resp", {63'd0, stall}, 64'd0);
    step();
    chk("lw_wb_pulse_end", {63'd0, wb_valid}, 64'd0);

    // SB 0x2003, ack on the third BUS cycle
    issue(1'b0, 1'b1, 3'b000, 64'h2003, 64'hAB, 5'd7);
    #1;
    stall_cnt = stall ? 1 : 0;
    wb_seen = 0;
    step();
    drop();
    chk("sb_mem_be", {56'd0, mem_be}, 64'h08);
    chk("sb_mem_wdata", mem_wdata, 64'h0000_0000_AB00_0000);
    chk("sb_mem_we", {63'd0, mem_we}, 64'd1);
    chk("sb_mem_addr", mem_addr, 64'h2000);
    for (int i = 0; i < 3; i++) begin
      if (stall) stall_cnt++;
      if (wb_valid) wb_seen++;
      if (i == 2) mem_ack = 1'b1;
      step();
    end
    mem_ack = 1'b0;
    if (wb_valid) wb_seen++;
    chk("sb_stall_cycles", 64'(stall_cnt), 64'd4);
    chk("sb_req_drop", {63'd0, mem_req}, 64'd0);
    chk("sb_stall_after", {63'd0, stall}, 64'd0);
    step();
    if (wb_valid) wb_seen++;
    chk("sb_no_wb", 64'(wb_seen), 64'd0);

    // LH 0x3001 misaligned
    issue(1'b1, 1'b0, 3'b001, 64'h3001, 64'd0, 5'd3);
    step();
    drop();
    chk("lh_misaligned", {63'd0, misaligned}, 64'd1);
    chk("lh_no_fault", {63'd0, access_fault}, 64'd0);
    chk("lh_fault_addr", fault_addr, 64'h3001);
    chk("lh_no_req", {63'd0, mem_req}, 64'd0);
    chk("lh_stall_exc", {63'd0, stall}, 64'd0);
    step();
    chk("lh_pulse_end", {63'd0, misaligned}, 64'd0);
    chk("lh_no_req2", {63'd0, mem_req}, 64'd0);

    // LD 0x4008 with no ack: timeout after 4 BUS cycles
    issue(1'b1, 1'b0, 3'b011, 64'h4008, 64'd0, 5'd9);
    step();
    drop();
    req_cnt = 0;
    flt_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      if (mem_req) req_cnt++;
      if (access_fault) begin
        flt_cnt++;
        chk("to_fault_addr", fault_addr, 64'h4008);
      end
      step();
    end
    chk("to_req_cycles", 64'(req_cnt), 64'd4);
    chk("to_fault_pulses", 64'(flt_cnt), 64'd1);
    chk("to_stall_idle", {63'd0, stall}, 64'd0);

    // load funct3 111 is illegal
    issue(1'b1, 1'b0, 3'b111, 64'h5000, 64'd0, 5'd1);
    step();
    drop();
    chk("ill_fault", {63'd0, access_fault}, 64'd1);
    chk("ill_no_misal", {63'd0, misaligned}, 64'd0);
    chk("ill_fault_addr", fault_addr, 64'h5000);
    chk("ill_no_req", {63'd0, mem_req}, 64'd0);
    step();
    chk("ill_pulse_end", {63'd0, access_fault}, 64'd0);

    // LBU byte 2 = 0x80
    issue(1'b1, 1'b0, 3'b100, 64'h6002, 64'd0, 5'd12);
    step();
    drop();
    chk("lbu_mem_be", {56'd0, mem_be}, 64'h04);
    mem_ack = 1'b1; mem_rdata = 64'hFFFF_FFFF_FF80_FFFF;
    step();
    mem_ack = 1'b0;
    chk("lbu_wb_data", wb_data, 64'h80);
    chk("lbu_wb_rd", {59'd0, wb_rd}, 64'd12);
    step();

    // LB same lane sign-extends
    issue(1'b1, 1'b0, 3'b000, 64'h6002, 64'd0, 5'd13);
    step();
    drop();
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    chk("lb_wb_data", wb_data, 64'hFFFF_FFFF_FFFF_FF80);
    step();

    // both flags set resolves to a store; SD full lane
    issue(1'b1, 1'b1, 3'b011, 64'h7000, 64'h0123_4567_89AB_CDEF, 5'd2);
    step();
    drop();
    chk("sd_mem_we", {63'd0, mem_we}, 64'd1);
    chk("sd_mem_be", {56'd0, mem_be}, 64'hFF);
    chk("sd_mem_wdata", mem_wdata, 64'h0123_4567_89AB_CDEF);
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    chk("sd_no_wb", {63'd0, wb_valid}, 64'd0);
    chk("sd_idle_stall", {63'd0, stall}, 64'd0);

    // reset in the middle of BUS
    issue(1'b1, 1'b0, 3'b010, 64'h8000, 64'd0, 5'd4);
    step();
    drop();
    chk("rb_mem_req", {63'd0, mem_req}, 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rb_req_drop", {63'd0, mem_req}, 64'd0);
    chk("rb_stall", {63'd0, stall}, 64'd0);
    step();
    rst_n = 1'b1;
    wb_seen = 0;
    flt_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (wb_valid) wb_seen++;
      if (access_fault || misaligned) flt_cnt++;
      if (stall) flt_cnt++;
    end
    chk("rb_no_wb", 64'(wb_seen), 64'd0);
    chk("rb_no_fault_stall", 64'(flt_cnt), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
